toggle_event_rx: RTL
====================

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on t_in (legal 2..4).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the maximum pending events held (legal 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port t_in, input, 1 bit: the toggle request line from the sender's T flip-flop, asynchronous to clk, one event per level change.
REQ-006 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts an event when high together with evt_valid.
REQ-007 The block SHALL have port evt_valid, output, 1 bit: at least one event is pending.
REQ-008 The block SHALL have port ack_t, output, 1 bit: the toggle acknowledge to the sender, changing level once per consumed event.
REQ-009 The block SHALL have port pending, output, 3 bits: the current count of pending events.
REQ-010 The block SHALL have port evt_total, output, 8 bits: a wrapping count of consumed events.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky flag meaning an event was dropped.

Function
REQ-012 t_in SHALL pass through a SYNC_STAGES-flop synchronizer; only the last stage (t_s) SHALL be used internally.
REQ-013 An event edge SHALL be detected as t_s XOR t_prev, where t_prev is t_s registered one cycle.
REQ-014 Control FSM states SHALL be WARMUP and RUN; reset SHALL enter WARMUP.
REQ-015 WARMUP SHALL last exactly SYNC_STAGES+1 cycles after reset deasserts, then go to RUN; edges SHALL be ignored in WARMUP and t_prev SHALL track t_s, so a static t_in=1 at reset produces no event.
REQ-016 In RUN, an edge SHALL increment pending at the next clk edge; with a t_in change stable before sampling edge k, evt_valid SHALL be high after edge k+SYNC_STAGES (3 edges at default).
REQ-017 evt_valid SHALL equal (pending != 0), registered, never combinational from evt_ready.
REQ-018 Pop = evt_valid AND evt_ready; on pop, pending SHALL decrement, ack_t SHALL toggle and evt_total SHALL increment, all at the same clk edge.
REQ-019 Simultaneous edge and pop SHALL leave pending unchanged while still toggling ack_t and incrementing evt_total.
REQ-020 An edge with pending==DEPTH and no pop SHALL be dropped; pending SHALL stay at DEPTH and ovf SHALL set.
REQ-021 An edge with pending==DEPTH and a pop in the same cycle SHALL NOT count as an overflow.
REQ-022 ovf SHALL remain set until reset.
REQ-023 evt_total SHALL wrap from 255 to 0 with no flag.
REQ-024 evt_ready while evt_valid is low SHALL have no effect.

Reset
REQ-025 While reset is high at a clk edge, all synchronizer stages, t_prev, pending, evt_valid, ack_t, evt_total and ovf SHALL go to 0 and the FSM SHALL go to WARMUP.
REQ-026 Reset mid-operation SHALL discard pending events with no ack_t toggle for them; the sender is responsible for re-aligning via its own reset.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (WARMUP, RUN), the default SYNC_STAGES and DEPTH, and the pending and evt_total widths.
REQ-029 The synchronizer SHALL be a separate sub-module sync_ff_chain (parameter STAGES, ports clk, reset, d, q), reused elsewhere.
REQ-030 The top level SHALL contain the FSM, edge detector, pending counter, ack toggle flop, total counter and ovf flag.

Verification
REQ-031 Hold t_in=1 through reset, release -> no evt_valid for 20 cycles, ovf=0, pending=0.
REQ-032 After warmup, toggle t_in once with evt_ready=1 -> evt_valid high for exactly 1 cycle starting 3 edges after sampling, ack_t toggles once, evt_total=1.
REQ-033 With evt_ready=0, toggle t_in 5 times with 4-cycle spacing -> pending saturates at 4, ovf=1; then evt_ready=1 -> 4 pops, ack_t toggles 4 times, evt_total=4, ovf stays 1.
REQ-034 With pending=4, toggle arrives in the same cycle as a pop -> pending stays 4, ovf stays 0.
REQ-035 Drive 256 toggle/consume events -> evt_total returns to 0, ack_t ends at 0 (even count).
REQ-036 Assert reset with pending=3 -> next cycle pending=0, evt_valid=0, ack_t=0, evt_total=0, ovf=0, FSM in WARMUP.

Source files
------------

// File: rtl/toggle_event_rx_pkg.sv
// Shared types and sizing for the toggle-handshake event receiver.
package toggle_event_rx_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned PEND_W          = 3;
    localparam int unsigned TOTAL_W         = 8;
    localparam int unsigned WARM_W          = 3;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receives toggle-encoded events, queues them as a count, and acknowledges
// each consumed event by toggling ack_t back to the sender.
module toggle_event_rx
    import toggle_event_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEPTH       = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               t_in,
    input  logic               evt_ready,
    output logic               evt_valid,
    output logic               ack_t,
    output logic [PEND_W-1:0]  pending,
    output logic [TOTAL_W-1:0] evt_total,
    output logic               ovf
);

    logic               t_s;
    logic               t_prev_q;
    state_t             state_q;
    logic [WARM_W-1:0]  warm_q;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               valid_q;
    logic               ack_q;
    logic [TOTAL_W-1:0] total_q;
    logic               ovf_q, ovf_d;
    logic               edge_seen;
    logic               pop;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (t_s)
    );

    assign edge_seen = (state_q == RUN) && (t_s ^ t_prev_q);
    assign pop       = valid_q && evt_ready;

    // A pop in the same cycle frees a slot, so a full queue only drops when not popping.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (edge_seen && !pop) begin
            if (pend_q == PEND_W'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (pop && !edge_seen) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WARMUP;
            warm_q   <= '0;
            t_prev_q <= 1'b0;
            pend_q   <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            total_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            t_prev_q <= t_s;
            pend_q   <= pend_d;
            valid_q  <= (pend_d != '0);
            ack_q    <= ack_q ^ pop;
            total_q  <= total_q + TOTAL_W'(pop);
            ovf_q    <= ovf_d;
            case (state_q)
                WARMUP: begin
                    if (warm_q == WARM_W'(SYNC_STAGES)) begin
                        state_q <= RUN;
                    end else begin
                        warm_q <= warm_q + WARM_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign evt_valid = valid_q;
    assign ack_t     = ack_q;
    assign pending   = pend_q;
    assign evt_total = total_q;
    assign ovf       = ovf_q;

endmodule
